seg_disp20: RTL
===============

SEG_DISP20 -- requirements
Module: seg_disp20

Interface
REQ-001 The block SHALL take parameter REFRESH_DIV, default 1000, giving mclk cycles per displayed digit; legal range 2..65535.
REQ-002 mclk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 count_in  input  5  value from the mod-20 up/down counter; legal range 0..19.
REQ-005 err_clr  input  1  synchronous clear of the sticky error flag.
REQ-006 seg  output  7  segment drive, active-high, bit0=a ... bit6=g.
REQ-007 an  output  2  digit enable, active-low; an[0]=ones digit, an[1]=tens digit.
REQ-008 up_pulse  output  1  one-cycle pulse on a +1 step, including 19->0.
REQ-009 down_pulse  output  1  one-cycle pulse on a -1 step, including 0->19.
REQ-010 wrap_pulse  output  1  one-cycle pulse on a 19->0 or 0->19 step.
REQ-011 last_dir  output  1  direction of the last legal step; 1=up, 0=down.
REQ-012 err  output  1  sticky flag for an illegal value or a non-adjacent step.

Function
REQ-013 count_in SHALL be registered into count_q every cycle; prev_q SHALL take the old count_q value on every cycle.
REQ-014 A valid bit SHALL be set on the first cycle after reset in which count_q is loaded; step classification SHALL be suppressed until both count_q and prev_q hold post-reset samples.
REQ-015 Step classification SHALL compare count_q with prev_q:
 - equal -> no pulse;
 - count_q = prev_q+1, or prev_q=19 and count_q=0 -> up_pulse;
 - count_q = prev_q-1, or prev_q=0 and count_q=19 -> down_pulse;
 - any other pair -> set err.
REQ-016 wrap_pulse SHALL assert in the same cycle as the up_pulse or down_pulse of a wrap step.
REQ-017 All pulses SHALL be registered and high for exactly one cycle, visible after the 2nd rising edge following the count_in change.
REQ-018 last_dir SHALL update with each up_pulse or down_pulse and hold otherwise.
REQ-019 count_q greater than 19 SHALL set err, display dash on both digits (seg=0x40), and suppress step classification involving that sample.
REQ-020 BCD split: tens = 1 if count_q >= 10, else 0; ones = count_q - 10*tens; pure 5-bit arithmetic, no divider.
REQ-021 Digit encodings SHALL be 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F for 0..9.
REQ-022 Leading-zero blanking: when tens=0 and the tens digit is selected, seg SHALL be 0x00 while an=2'b01 is still driven.
REQ-023 Refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count it SHALL wrap to 0 and toggle digit select.
REQ-024 Digit select 0 SHALL drive an=2'b10 with the ones segments; select 1 SHALL drive an=2'b01 with the tens segments.
REQ-025 seg and an SHALL be registered; seg SHALL reflect count_in 2 cycles after it changes.
REQ-026 err_clr SHALL clear err the next cycle; if err_clr coincides with a new error, err SHALL remain set.

Reset
REQ-027 On reset the block SHALL load: count_q=0, prev_q=0, valid=0, refresh counter=0, digit select=0, seg=0x00, an=2'b11, all pulses=0, last_dir=1, err=0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-refresh and mid-step.
REQ-029 After reset the first classification SHALL occur only once two fresh samples are held; no pulse SHALL be generated against a pre-reset value.

Structure
REQ-030 The shared package SHALL hold the segment encoding constants for 0..9, blank and dash, plus the constants MOD_MAX=19 and WIDTH=5.
REQ-031 The segment encoder SHALL be a sub-module named seg7_enc (4-bit digit in, 7-bit segments out, with blank and dash selects).

Verification
REQ-032 Cover these directed scenarios (REFRESH_DIV=4):
 - count_in 5->6 -> up_pulse=1 for exactly one cycle, 2 cycles after the change; last_dir=1; wrap_pulse=0.
 - count_in 19->0 -> up_pulse=1 and wrap_pulse=1 in the same cycle; 0->19 -> down_pulse=1 and wrap_pulse=1; last_dir=0.
 - count_in 3->7 -> err=1 with no pulse; err_clr=1 -> err=0 the next cycle.
 - count_in=23 -> seg=0x40 on both digits and err=1.
 - count_in=14 -> an alternates 2'b10/2'b01 every 4 cycles with seg=0x66/0x06; count_in=7 -> tens slot shows seg=0x00.
 - reset asserted mid-run with count_in=12 -> outputs match the REQ-027 values on the next cycle; no pulse on the first post-reset sample.

Source files
------------

// File: rtl/seg_disp20_pkg.sv
// seg_disp20_pkg: shared widths, counter limits and seven-segment encodings.
package seg_disp20_pkg;
    localparam int WIDTH = 5;
    localparam logic [WIDTH-1:0] MOD_MAX = 5'd19;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    function automatic logic [6:0] seg_of(logic [3:0] d);
        return d > 4'd9 ? SEG_BLANK : SEG_LUT[d];
    endfunction
endpackage

// File: rtl/seg_disp20_if.sv
// seg_disp20_if: counter input, error clear and display/step outputs.
interface seg_disp20_if;
    import seg_disp20_pkg::*;
    logic [WIDTH-1:0] count_in;
    logic err_clr;
    logic [6:0] seg;
    logic [1:0] an;
    logic up_pulse;
    logic down_pulse;
    logic wrap_pulse;
    logic last_dir;
    logic err;
    modport master (
        output count_in, err_clr,
        input seg, an, up_pulse, down_pulse, wrap_pulse, last_dir, err
    );
    modport slave (
        input count_in, err_clr,
        output seg, an, up_pulse, down_pulse, wrap_pulse, last_dir, err
    );
endinterface

// File: rtl/seg_disp20_seg7_enc.sv
// seg7_enc: BCD digit to active-high segments; dash overrides blank.
module seg7_enc
    import seg_disp20_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    assign seg = dash ? SEG_DASH : blank ? SEG_BLANK : seg_of(digit);
endmodule

// File: rtl/seg_disp20.sv
// seg_disp20: mod-20 counter monitor with step/wrap detection and a
// two-digit multiplexed seven-segment display.
module seg_disp20
    import seg_disp20_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input logic mclk,
    input logic reset,
    seg_disp20_if.slave bus
);
    localparam logic [15:0] TC = 16'(REFRESH_DIV - 1);
    logic [WIDTH-1:0] count_q, prev_q;
    logic valid, prev_valid, sel;
    logic [15:0] rcnt;
    logic legal, classify, step_up, step_dn, wrap, new_err, tens;
    logic [3:0] ones;
    logic [6:0] seg_next;
    assign legal = count_q <= MOD_MAX && prev_q <= MOD_MAX;
    // prev_valid means prev_q also holds a post-reset sample
    assign classify = prev_valid && legal;
    assign wrap = (prev_q == MOD_MAX && count_q == '0) || (prev_q == '0 && count_q == MOD_MAX);
    assign step_up = (prev_q == MOD_MAX && count_q == '0) ||
                     (prev_q != MOD_MAX && count_q == prev_q + 5'd1);
    assign step_dn = (prev_q == '0 && count_q == MOD_MAX) ||
                     (prev_q != '0 && count_q == prev_q - 5'd1);
    assign new_err = (valid && count_q > MOD_MAX) ||
                     (classify && count_q != prev_q && !step_up && !step_dn);
    assign tens = count_q >= 5'd10;
    // mod-16 subtraction is exact here since ones never exceeds 9
    assign ones = count_q[3:0] - (tens ? 4'd10 : 4'd0);
    seg7_enc u_enc (
        .digit(sel ? {3'b000, tens} : ones),
        .blank(sel && !tens),
        .dash (count_q > MOD_MAX),
        .seg  (seg_next)
    );
    always_ff @(posedge mclk) begin
        if (reset) begin
            count_q         <= '0;
            prev_q          <= '0;
            valid           <= 1'b0;
            prev_valid      <= 1'b0;
            rcnt            <= '0;
            sel             <= 1'b0;
            bus.seg         <= SEG_BLANK;
            bus.an          <= 2'b11;
            bus.up_pulse    <= 1'b0;
            bus.down_pulse  <= 1'b0;
            bus.wrap_pulse  <= 1'b0;
            bus.last_dir    <= 1'b1;
            bus.err         <= 1'b0;
        end else begin
            prev_q          <= count_q;
            count_q         <= bus.count_in;
            valid           <= 1'b1;
            prev_valid      <= valid;
            rcnt            <= rcnt == TC ? '0 : rcnt + 16'd1;
            sel             <= rcnt == TC ? !sel : sel;
            bus.seg         <= seg_next;
            bus.an          <= sel ? 2'b01 : 2'b10;
            bus.up_pulse    <= classify && step_up;
            bus.down_pulse  <= classify && step_dn;
            bus.wrap_pulse  <= classify && wrap;
            bus.last_dir    <= classify && step_up ? 1'b1 : classify && step_dn ? 1'b0 : bus.last_dir;
            bus.err         <= new_err || (bus.err && !bus.err_clr);
        end
    end
endmodule
